wb_status_irq: RTL and testbench

- Wishbone-domain status register and interrupt block, directly downstream of the status clock-domain synchroniser.
- Consumes its single-cycle status pulses (eight events) and synchronised fault levels (two).
- Latches events into sticky pending bits, counts the three frame-error types, and raises a maskable interrupt.
- The host reads and clears everything over a classic Wishbone slave port.

---
 rtl/wb_status_pkg.sv | 26 ++
 rtl/sat_event_cnt.sv | 30 +++
 rtl/wb_status_irq.sv | 147 ++++++++++++++
 tb/tb_wb_status_irq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_status_pkg.sv
// Shared constants for the Wishbone status/interrupt block: register map,
// pending-bit positions and the number of latched status sources.
package wb_status_pkg;

  localparam int NUM_STATUS = 10;

  // Byte offsets, compared against the word-aligned bus address.
  localparam logic [31:0] REG_INT_PENDING  = 32'h00;
  localparam logic [31:0] REG_INT_MASK     = 32'h04;
  localparam logic [31:0] REG_INT_STATUS   = 32'h08;
  localparam logic [31:0] REG_CRC_ERR_CNT  = 32'h0C;
  localparam logic [31:0] REG_FRAG_ERR_CNT = 32'h10;
  localparam logic [31:0] REG_LEN_ERR_CNT  = 32'h14;

  localparam int BIT_PAUSE        = 0;
  localparam int BIT_RXD_UDFLOW   = 1;
  localparam int BIT_RXD_OVFLOW   = 2;
  localparam int BIT_TXD_UDFLOW   = 3;
  localparam int BIT_TXD_OVFLOW   = 4;
  localparam int BIT_FRAG_ERR     = 5;
  localparam int BIT_CRC_ERR      = 6;
  localparam int BIT_LEN_ERR      = 7;
  localparam int BIT_LOCAL_FAULT  = 8;
  localparam int BIT_REMOTE_FAULT = 9;

endpackage

// File: rtl/sat_event_cnt.sv
// Saturating event counter with synchronous clear; an increment arriving on
// the clearing edge wins and leaves the counter at 1 so no event is lost.
module sat_event_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      if (clr) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/wb_status_irq.sv
// Wishbone status register and interrupt block: sticky pending bits, fault
// edge detection, three saturating frame-error counters and a masked IRQ.
module wb_status_irq
  import wb_status_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  status_pause_frame_rx,
  input  logic                  status_rxdfifo_udflow,
  input  logic                  status_rxdfifo_ovflow,
  input  logic                  status_txdfifo_udflow,
  input  logic                  status_txdfifo_ovflow,
  input  logic                  status_fragment_error,
  input  logic                  status_crc_error,
  input  logic                  status_lenght_error,
  input  logic                  status_local_fault,
  input  logic                  status_remote_fault,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_int_o
);

  logic [NUM_STATUS-1:0] pending;
  logic [NUM_STATUS-1:0] mask;
  logic [NUM_STATUS-1:0] events;
  logic                  local_hist;
  logic                  remote_hist;
  logic [CNT_WIDTH-1:0]  crc_cnt;
  logic [CNT_WIDTH-1:0]  frag_cnt;
  logic [CNT_WIDTH-1:0]  len_cnt;
  logic [31:0]           adr32;
  logic [31:0]           rd_data;
  logic                  req;
  logic                  rd_req;
  logic                  wr_req;
  logic                  unused_bits;

  // Handshake: a request is cyc & stb while ack is low; it is always accepted
  // and answered by a single-cycle registered ack on the next edge, with
  // wb_dat_o loaded on that same edge and held at zero otherwise.
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd_req = req & ~wb_we_i;
  assign wr_req = req & wb_we_i;

  always_comb begin
    adr32 = '0;
    adr32[ADDR_WIDTH-1:2] = wb_adr_i[ADDR_WIDTH-1:2];
  end

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:NUM_STATUS]};

  always_comb begin
    events                   = '0;
    events[BIT_PAUSE]        = status_pause_frame_rx;
    events[BIT_RXD_UDFLOW]   = status_rxdfifo_udflow;
    events[BIT_RXD_OVFLOW]   = status_rxdfifo_ovflow;
    events[BIT_TXD_UDFLOW]   = status_txdfifo_udflow;
    events[BIT_TXD_OVFLOW]   = status_txdfifo_ovflow;
    events[BIT_FRAG_ERR]     = status_fragment_error;
    events[BIT_CRC_ERR]      = status_crc_error;
    events[BIT_LEN_ERR]      = status_lenght_error;
    events[BIT_LOCAL_FAULT]  = status_local_fault ^ local_hist;
    events[BIT_REMOTE_FAULT] = status_remote_fault ^ remote_hist;
  end

  always_comb begin
    rd_data = '0;
    case (adr32)
      REG_INT_PENDING:  rd_data[NUM_STATUS-1:0] = pending;
      REG_INT_MASK:     rd_data[NUM_STATUS-1:0] = mask;
      REG_INT_STATUS: begin
        rd_data[BIT_LOCAL_FAULT]  = status_local_fault;
        rd_data[BIT_REMOTE_FAULT] = status_remote_fault;
      end
      REG_CRC_ERR_CNT:  rd_data = 32'(crc_cnt);
      REG_FRAG_ERR_CNT: rd_data = 32'(frag_cnt);
      REG_LEN_ERR_CNT:  rd_data = 32'(len_cnt);
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd_req ? rd_data : '0;
    end
  end

  // New events are OR-ed in after the read-clear so a coincident set wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pending     <= '0;
      mask        <= '0;
      local_hist  <= 1'b0;
      remote_hist <= 1'b0;
      wb_int_o    <= 1'b0;
    end else begin
      local_hist  <= status_local_fault;
      remote_hist <= status_remote_fault;
      wb_int_o    <= |(pending & mask);
      if (rd_req && adr32 == REG_INT_PENDING) begin
        pending <= events;
      end else begin
        pending <= pending | events;
      end
      if (wr_req && adr32 == REG_INT_MASK) begin
        mask <= wb_dat_i[NUM_STATUS-1:0];
      end
    end
  end

  sat_event_cnt #(.WIDTH(CNT_WIDTH)) u_crc_cnt (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .inc   (status_crc_error),
    .clr   (rd_req && adr32 == REG_CRC_ERR_CNT),
    .cnt   (crc_cnt)
  );

  sat_event_cnt #(.WIDTH(CNT_WIDTH)) u_frag_cnt (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .inc   (status_fragment_error),
    .clr   (rd_req && adr32 == REG_FRAG_ERR_CNT),
    .cnt   (frag_cnt)
  );

  sat_event_cnt #(.WIDTH(CNT_WIDTH)) u_len_cnt (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .inc   (status_lenght_error),
    .clr   (rd_req && adr32 == REG_LEN_ERR_CNT),
    .cnt   (len_cnt)
  );

endmodule

// File: tb/tb_wb_status_irq.sv
// Directed bench for wb_status_irq, built with 4-bit counters so that
// saturation is reachable in a handful of pulses.
module tb_wb_status_irq;
  import wb_status_pkg::*;

  localparam int CW = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n;
  logic [7:0]  ev;
  logic        local_fault;
  logic        remote_fault;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_int_o;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_status_irq #(.CNT_WIDTH(CW), .ADDR_WIDTH(8)) dut (
    .wb_clk_i              (wb_clk_i),
    .wb_rst_n              (wb_rst_n),
    .status_pause_frame_rx (ev[0]),
    .status_rxdfifo_udflow (ev[1]),
    .status_rxdfifo_ovflow (ev[2]),
    .status_txdfifo_udflow (ev[3]),
    .status_txdfifo_ovflow (ev[4]),
    .status_fragment_error (ev[5]),
    .status_crc_error      (ev[6]),
    .status_lenght_error   (ev[7]),
    .status_local_fault    (local_fault),
    .status_remote_fault   (remote_fault),
    .wb_adr_i              (wb_adr_i),
    .wb_dat_i              (wb_dat_i),
    .wb_dat_o              (wb_dat_o),
    .wb_we_i               (wb_we_i),
    .wb_stb_i              (wb_stb_i),
    .wb_cyc_i              (wb_cyc_i),
    .wb_ack_o              (wb_ack_o),
    .wb_int_o              (wb_int_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One full access: request, ack the next cycle, then idle with data at zero.
  task automatic bus_cycle(input logic [7:0] adr, input logic we, input logic [31:0] wd,
                           input logic [7:0] ev_in, output logic [31:0] rdat);
    @(posedge wb_clk_i); #1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wd;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; ev = ev_in;
    @(posedge wb_clk_i); #1;
    check("ack_high", {31'b0, wb_ack_o}, 32'd1);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; ev = '0;
    @(posedge wb_clk_i); #1;
    check("ack_single", {31'b0, wb_ack_o}, 32'd0);
    check("dat_idle", wb_dat_o, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [31:0] exp,
                        input logic [7:0] ev_in);
    logic [31:0] r;
    exp_q.push_back(exp);
    bus_cycle(adr, 1'b0, 32'd0, ev_in, r);
    check(tag, r, exp_q.pop_front());
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] wd);
    logic [31:0] r;
    bus_cycle(adr, 1'b1, wd, 8'h00, r);
  endtask

  task automatic pulse(input logic [7:0] ev_in, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk_i); #1;
      ev = ev_in;
    end
    @(posedge wb_clk_i); #1;
    ev = '0;
  endtask

  initial begin
    wb_rst_n = 1'b0; ev = '0; local_fault = 1'b0; remote_fault = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_int", {31'b0, wb_int_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    wb_rst_n = 1'b1;

    rd_chk("rst_pending", 8'h00, 32'h0, 8'h00);
    rd_chk("rst_mask", 8'h04, 32'h0, 8'h00);
    rd_chk("rst_crc_cnt", 8'h0C, 32'h0, 8'h00);
    check("idle_int", {31'b0, wb_int_o}, 32'd0);

    // Masked CRC event: interrupt two cycles after the pulse, cleared by read.
    wr(8'h04, 32'h0000_00FF);
    pulse(8'h40, 1);
    check("int_n1", {31'b0, wb_int_o}, 32'd0);
    @(posedge wb_clk_i); #1;
    check("int_n2", {31'b0, wb_int_o}, 32'd1);
    rd_chk("pend_crc", 8'h00, 32'h40, 8'h00);
    check("int_after_clr", {31'b0, wb_int_o}, 32'd0);
    rd_chk("pend_cleared", 8'h00, 32'h0, 8'h00);

    rd_chk("crc_cnt_1", 8'h0C, 32'd1, 8'h00);
    pulse(8'h40, 5);
    rd_chk("crc_cnt_5", 8'h0C, 32'd5, 8'h00);
    rd_chk("crc_cnt_rc", 8'h0C, 32'd0, 8'h00);
    pulse(8'h40, 2);
    rd_chk("crc_cnt_race", 8'h0C, 32'd2, 8'h40);
    rd_chk("crc_cnt_setwins", 8'h0C, 32'd1, 8'h00);

    pulse(8'h80, 20);
    rd_chk("len_cnt_sat", 8'h14, 32'h0000_000F, 8'h00);
    rd_chk("len_cnt_rc", 8'h14, 32'd0, 8'h00);
    pulse(8'h20, 3);
    rd_chk("frag_cnt_3", 8'h10, 32'd3, 8'h00);
    rd_chk("pend_err3", 8'h00, 32'h0E0, 8'h00);

    // Fault level change with the interrupt masked off.
    wr(8'h04, 32'h0);
    local_fault = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("fault_masked_int", {31'b0, wb_int_o}, 32'd0);
    rd_chk("status_live", 8'h08, 32'h100, 8'h00);
    wr(8'h04, 32'h100);
    check("fault_int", {31'b0, wb_int_o}, 32'd1);
    rd_chk("mask_rb", 8'h04, 32'h100, 8'h00);
    rd_chk("pend_local", 8'h00, 32'h100, 8'h00);
    check("fault_int_clr", {31'b0, wb_int_o}, 32'd0);

    wr(8'h04, 32'hFFFF_FFFF);
    rd_chk("mask_unused", 8'h04, 32'h3FF, 8'h00);

    // Every source in one cycle, including both fault transitions.
    @(posedge wb_clk_i); #1;
    ev = 8'hFF; local_fault = 1'b0; remote_fault = 1'b1;
    @(posedge wb_clk_i); #1;
    ev = 8'h00;
    rd_chk("status_remote", 8'h08, 32'h200, 8'h00);
    rd_chk("unmapped_rd", 8'h18, 32'h0, 8'h00);
    wr(8'h1C, 32'h0);
    wr(8'h08, 32'h0);
    rd_chk("mask_kept", 8'h04, 32'h3FF, 8'h00);
    check("all_int", {31'b0, wb_int_o}, 32'd1);

    // Reset in the middle of an acked read of pending=0x3FF.
    @(posedge wb_clk_i); #1;
    wb_adr_i = 8'h00; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("pre_rst_ack", {31'b0, wb_ack_o}, 32'd1);
    check("pre_rst_dat", wb_dat_o, 32'h3FF);
    wb_rst_n = 1'b0;
    #1;
    check("async_ack", {31'b0, wb_ack_o}, 32'd0);
    check("async_int", {31'b0, wb_int_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; remote_fault = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #2;
    wb_rst_n = 1'b1;
    rd_chk("post_rst_pend", 8'h00, 32'h0, 8'h00);
    rd_chk("post_rst_mask", 8'h04, 32'h0, 8'h00);
    rd_chk("post_rst_crc", 8'h0C, 32'h0, 8'h00);
    check("post_rst_int", {31'b0, wb_int_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
